// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin sharing of one fixed-latency divider.
// A tag pipeline tracks each operation so quotients return to their owner.
module div_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_num,
  input  logic [16*NUM_REQ-1:0] req_den,
  output logic [15:0]           div_num,
  output logic [15:0]           div_den,
  input  logic [15:0]           div_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [16*NUM_REQ-1:0] rsp_data,
  output logic [NUM_REQ-1:0]    rsp_dz,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic                  idle
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int NST   = DIV_LATENCY + 1;
  localparam int LST   = DIV_LATENCY;

  logic [NUM_REQ-1:0]        r_pending;
  logic [IDX_W-1:0]          r_ptr;
  logic [NST-1:0]            r_tag_v;
  logic [NST-1:0]            r_tag_dz;
  logic [NST-1:0][IDX_W-1:0] r_tag_idx;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_rsp_hs;
  logic               w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [15:0]        w_gnt_num;
  logic [15:0]        w_gnt_den;
  logic               w_gnt_dz;
  logic               w_cap;
  logic [IDX_W-1:0]   w_cap_idx;
  logic               w_cap_dz;
  logic [15:0]        w_cap_data;

  // A requester with an operation outstanding is not eligible again.
  assign w_elig   = req_valid & ~r_pending;
  assign w_rsp_hs = rsp_valid & rsp_ready;

  // First eligible requester at or after the pointer wins.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_gnt && w_elig[w_cand]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // One-hot accept and operand mux for the winner.
  always_comb begin
    req_ready = '0;
    w_gnt_num = '0;
    w_gnt_den = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == IDX_W'(i)) begin
        req_ready[i] = w_gnt;
        w_gnt_num    = req_num[16*i +: 16];
        w_gnt_den    = req_den[16*i +: 16];
      end
    end
  end

  assign w_gnt_dz  = (w_gnt_den == 16'd0);
  assign w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ?
                     '0 : w_gnt_idx + 1'b1;

  // Pointer moves just past the winner; holds when nobody is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_gnt) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Pending tracks one outstanding operation per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt && w_gnt_idx == IDX_W'(i)) begin
          r_pending[i] <= 1'b1;
        end else if (w_rsp_hs[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Operands are launched to the divider only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_num <= '0;
      div_den <= '0;
    end else if (w_gnt) begin
      div_num <= w_gnt_num;
      div_den <= w_gnt_den;
    end
  end

  // Tag pipeline: free-running shift matched to the divider latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v   <= '0;
      r_tag_dz  <= '0;
      r_tag_idx <= '0;
    end else begin
      r_tag_v[0]   <= w_gnt;
      r_tag_dz[0]  <= w_gnt_dz;
      r_tag_idx[0] <= w_gnt_idx;
      for (int s = 1; s < NST; s++) begin
        r_tag_v[s]   <= r_tag_v[s-1];
        r_tag_dz[s]  <= r_tag_dz[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  // The last tag stage lines up with the quotient for its operands.
  assign w_cap      = r_tag_v[LST];
  assign w_cap_idx  = r_tag_idx[LST];
  assign w_cap_dz   = r_tag_dz[LST];
  assign w_cap_data = w_cap_dz ? 16'hFFFF : div_result;

  // Response slots capture a quotient and hold it until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_dz    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_cap && w_cap_idx == IDX_W'(i)) begin
          rsp_valid[i]         <= 1'b1;
          rsp_data[16*i +: 16] <= w_cap_data;
          rsp_dz[i]            <= w_cap_dz;
        end else if (w_rsp_hs[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign idle = ~|r_pending;

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: scenario tasks plus a randomized run
// against a queue-based behavioural model of the arbiter.
module tb_div_share_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [16*NR-1:0] req_num = '0;
  logic [16*NR-1:0] req_den = '0;
  logic [15:0]     div_num, div_den, div_result;
  logic [NR-1:0]   rsp_valid;
  logic [16*NR-1:0] rsp_data;
  logic [NR-1:0]   rsp_dz;
  logic [NR-1:0]   rsp_ready = '0;
  logic            idle;

  always #5 clk = ~clk;

  div_share_arbiter #(.NUM_REQ(NR), .DIV_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_den(req_den),
    .div_num(div_num), .div_den(div_den), .div_result(div_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_dz(rsp_dz),
    .rsp_ready(rsp_ready), .idle(idle)
  );

  // Divider model: 3-edge pipeline; garbage on divide by zero.
  logic [15:0] d1 = '0, d2 = '0, d3 = '0;
  always @(posedge clk) begin
    d1 <= (div_den == 16'd0) ? (div_num ^ 16'hA5A5) : div_num / div_den;
    d2 <= d1;
    d3 <= d2;
  end
  assign div_result = d3;

  // Reference model
  typedef struct { int idx; int due; logic [15:0] q; bit dz; } fl_t;
  fl_t         m_fl[$];
  bit          m_pend[NR];
  bit          m_rv[NR];
  bit          m_rz[NR];
  logic [15:0] m_rd[NR];
  int          m_ptr;
  logic [15:0] m_dnum, m_dden;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int m_pick();
    int c;
    for (int k = 0; k < NR; k++) begin
      c = (m_ptr + k) % NR;
      if (req_valid[c] && !m_pend[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] m_ready();
    logic [NR-1:0] v;
    int g;
    v = '0;
    g = m_pick();
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [NR-1:0] m_rv_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_rv[i];
    return v;
  endfunction

  function automatic logic [NR-1:0] m_rz_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_rz[i];
    return v;
  endfunction

  function automatic logic [16*NR-1:0] m_rd_vec();
    logic [16*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[16*i +: 16] = m_rd[i];
    return v;
  endfunction

  function automatic logic m_idle();
    logic b;
    b = 1'b1;
    for (int i = 0; i < NR; i++) if (m_pend[i]) b = 1'b0;
    return b;
  endfunction

  function automatic void m_reset();
    m_fl.delete();
    for (int i = 0; i < NR; i++) begin
      m_pend[i] = 0; m_rv[i] = 0; m_rz[i] = 0; m_rd[i] = '0;
    end
    m_ptr = 0; m_dnum = '0; m_dden = '0;
  endfunction

  // One clock edge: update the model, then advance to the next negedge.
  task automatic tick();
    int g;
    logic [15:0] n, d;
    g = m_pick();
    for (int i = 0; i < NR; i++)
      if (m_rv[i] && rsp_ready[i]) begin m_rv[i] = 0; m_pend[i] = 0; end
    for (int j = m_fl.size() - 1; j >= 0; j--) begin
      if (m_fl[j].due == cyc + 1) begin
        m_rv[m_fl[j].idx] = 1;
        m_rd[m_fl[j].idx] = m_fl[j].q;
        m_rz[m_fl[j].idx] = m_fl[j].dz;
        m_fl.delete(j);
      end
    end
    if (g >= 0) begin
      n = req_num[16*g +: 16];
      d = req_den[16*g +: 16];
      m_pend[g] = 1;
      m_ptr = (g + 1) % NR;
      m_dnum = n; m_dden = d;
      m_fl.push_back('{g, cyc + 5, (d == 0) ? 16'hFFFF : n / d, d == 0});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(int i, logic [15:0] n, logic [15:0] d);
    req_valid[i] = 1'b1;
    req_num[16*i +: 16] = n;
    req_den[16*i +: 16] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; req_num = '0; req_den = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // A held slot must never change or drop until it is accepted.
  initial begin
    logic [NR-1:0] hold;
    logic [15:0]   hd[NR];
    logic          hz[NR];
    hold = '0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!rst && hold[i]) begin
          n_cmp++;
          if (rsp_valid[i] !== 1'b1 || rsp_data[16*i +: 16] !== hd[i] ||
              rsp_dz[i] !== hz[i]) begin
            n_bad++;
            $display("FAIL capture_overwrite slot %0d: got v=%b d=%h z=%b want v=1 d=%h z=%b",
                     i, rsp_valid[i], rsp_data[16*i +: 16], rsp_dz[i], hd[i], hz[i]);
          end
        end
        hold[i] = !rst && rsp_valid[i] && !rsp_ready[i];
        hd[i]   = rsp_data[16*i +: 16];
        hz[i]   = rsp_dz[i];
      end
    end
  end

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (div_num !== 16'h0) begin n_bad++; $display("FAIL rst_div_num: got %h want 0", div_num); end
    n_cmp++; if (div_den !== 16'h0) begin n_bad++; $display("FAIL rst_div_den: got %h want 0", div_den); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0000", rsp_valid); end
    n_cmp++; if (rsp_data !== 64'h0) begin n_bad++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    n_cmp++; if (rsp_dz !== 4'b0000) begin n_bad++; $display("FAIL rst_rsp_dz: got %b want 0000", rsp_dz); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %b want 1", idle); end
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_ptr0: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 16'd100, 16'd7);
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 1; c < 5; c++) begin
      #1;
      if (c == 1) begin
        n_cmp++; if (div_num !== 16'd100 || div_den !== 16'd7) begin n_bad++; $display("FAIL single_operands: got %0d/%0d want 100/7", div_num, div_den); end
      end
      n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_early c%0d: got %b want 0000", c, rsp_valid); end
      tick();
    end
    #1;
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL single_valid: got %b want 0001", rsp_valid); end
    n_cmp++; if (rsp_data[15:0] !== 16'd14) begin n_bad++; $display("FAIL single_data: got %0d want 14", rsp_data[15:0]); end
    n_cmp++; if (rsp_dz[0] !== 1'b0) begin n_bad++; $display("FAIL single_dz: got %b want 0", rsp_dz[0]); end
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", idle); end
    tick();
    #1;
    n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data[15:0] !== 16'd14) begin n_bad++; $display("FAIL single_hold: got %b/%0d want 0001/14", rsp_valid, rsp_data[15:0]); end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready = '0;
    #1;
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_clear: got %b want 0000", rsp_valid); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_all_four();
    logic [15:0]   n[NR], d[NR];
    logic [NR-1:0] exp;
    do_reset();
    rsp_ready = '1;
    for (int i = 0; i < NR; i++) begin
      n[i] = 16'($urandom);
      d[i] = 16'($urandom_range(1, 300));
      set_req(i, n[i], d[i]);
    end
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c < 4) begin
        exp = '0; exp[c] = 1'b1;
        n_cmp++; if (req_ready !== exp) begin n_bad++; $display("FAIL all4_grant c%0d: got %b want %b", c, req_ready, exp); end
      end
      exp = '0;
      if (c >= 5 && c < 9) exp[c-5] = 1'b1;
      n_cmp++; if (rsp_valid !== exp) begin n_bad++; $display("FAIL all4_rsp c%0d: got %b want %b", c, rsp_valid, exp); end
      if (c >= 5 && c < 9) begin
        n_cmp++; if (rsp_data[16*(c-5) +: 16] !== n[c-5] / d[c-5]) begin n_bad++; $display("FAIL all4_data slot %0d: got %h want %h", c - 5, rsp_data[16*(c-5) +: 16], n[c-5] / d[c-5]); end
      end
      tick();
      if (c < 4) req_valid[c] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int last, cnt1, cnt2, g;
    do_reset();
    rsp_ready = '1;
    set_req(1, 16'd1000, 16'd3);
    set_req(2, 16'd999, 16'd9);
    last = -1; cnt1 = 0; cnt2 = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      n_cmp++; if (req_ready !== m_ready()) begin n_bad++; $display("FAIL fair_ready c%0d: got %b want %b", c, req_ready, m_ready()); end
      n_cmp++; if (rsp_valid !== m_rv_vec()) begin n_bad++; $display("FAIL fair_rsp c%0d: got %b want %b", c, rsp_valid, m_rv_vec()); end
      g = -1;
      for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
      if (g >= 0) begin
        if (last >= 0) begin
          n_cmp++; if (g == last) begin n_bad++; $display("FAIL fair_alternate c%0d: got %0d want not %0d", c, g, last); end
        end
        if (g == 1) cnt1++;
        if (g == 2) cnt2++;
        last = g;
      end
      tick();
    end
    req_valid = '0;
    n_cmp++; if (cnt1 < 6 || cnt2 < 6) begin n_bad++; $display("FAIL fair_counts: got %0d/%0d want >=6 each", cnt1, cnt2); end
  endtask

  task automatic test_backpressure();
    int g2, gother, g, g2_after;
    logic [15:0] held;
    bit have;
    do_reset();
    rsp_ready = 4'b1011;
    for (int i = 0; i < NR; i++) set_req(i, 16'($urandom), 16'($urandom_range(1, 500)));
    g2 = 0; gother = 0; have = 0; held = '0;
    for (int c = 0; c < 30; c++) begin
      #1;
      n_cmp++; if (req_ready !== m_ready()) begin n_bad++; $display("FAIL bp_ready c%0d: got %b want %b", c, req_ready, m_ready()); end
      n_cmp++; if (rsp_valid !== m_rv_vec()) begin n_bad++; $display("FAIL bp_rsp c%0d: got %b want %b", c, rsp_valid, m_rv_vec()); end
      n_cmp++; if (rsp_data !== m_rd_vec()) begin n_bad++; $display("FAIL bp_data c%0d: got %h want %h", c, rsp_data, m_rd_vec()); end
      if (rsp_valid[2]) begin
        if (!have) begin held = rsp_data[47:32]; have = 1; end
        else begin
          n_cmp++; if (rsp_data[47:32] !== held) begin n_bad++; $display("FAIL bp_hold c%0d: got %h want %h", c, rsp_data[47:32], held); end
        end
      end
      g = -1;
      for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
      if (g == 2) g2++;
      else if (g >= 0) gother++;
      tick();
      if (g >= 0 && g != 2) set_req(g, 16'($urandom), 16'($urandom_range(1, 500)));
    end
    n_cmp++; if (g2 != 1) begin n_bad++; $display("FAIL bp_single_grant: got %0d want 1", g2); end
    n_cmp++; if (gother < 6) begin n_bad++; $display("FAIL bp_others_served: got %0d want >=6", gother); end
    #1;
    rsp_ready[2] = 1'b1;
    n_cmp++; if (req_ready[2] !== 1'b0) begin n_bad++; $display("FAIL bp_no_same_cycle: got %b want 0", req_ready[2]); end
    tick();
    g2_after = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++; if (req_ready !== m_ready()) begin n_bad++; $display("FAIL bp_rel_ready c%0d: got %b want %b", c, req_ready, m_ready()); end
      if (req_ready[2]) g2_after++;
      g = -1;
      for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
    end
    n_cmp++; if (g2_after != 1) begin n_bad++; $display("FAIL bp_regrant: got %0d want 1", g2_after); end
  endtask

  task automatic test_div_zero();
    do_reset();
    set_req(3, 16'd5, 16'd0);
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL dz_ready: got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 1; c < 5; c++) begin
      #1;
      n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL dz_early c%0d: got %b want 0000", c, rsp_valid); end
      tick();
    end
    #1;
    n_cmp++; if (rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL dz_valid: got %b want 1000", rsp_valid); end
    n_cmp++; if (rsp_data[63:48] !== 16'hFFFF) begin n_bad++; $display("FAIL dz_data: got %h want ffff", rsp_data[63:48]); end
    n_cmp++; if (rsp_dz !== 4'b1000) begin n_bad++; $display("FAIL dz_flag: got %b want 1000", rsp_dz); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rsp_ready = '1;
    set_req(0, 16'd500, 16'd5);
    set_req(1, 16'd81, 16'd9);
    #1;
    tick();
    req_valid[0] = 1'b0;
    #1;
    tick();
    req_valid[1] = 1'b0;
    #1;
    tick();
    #1;
    n_cmp++; if (idle !== 1'b0 || div_num !== 16'd81) begin n_bad++; $display("FAIL mid_busy: got idle=%b num=%0d want 0/81", idle, div_num); end
    tick();
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
    n_cmp++; if (div_num !== 16'h0 || div_den !== 16'h0) begin n_bad++; $display("FAIL mid_div: got %h/%h want 0/0", div_num, div_den); end
    n_cmp++; if (rsp_valid !== 4'b0000 || rsp_dz !== 4'b0000) begin n_bad++; $display("FAIL mid_rsp: got %b/%b want 0000/0000", rsp_valid, rsp_dz); end
    n_cmp++; if (rsp_data !== 64'h0) begin n_bad++; $display("FAIL mid_data: got %h want 0", rsp_data); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL mid_idle: got %b want 1", idle); end
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++; if (rsp_valid !== 4'b0000 || idle !== 1'b1) begin n_bad++; $display("FAIL mid_ghost c%0d: got v=%b idle=%b want 0000/1", c, rsp_valid, idle); end
      tick();
    end
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_ptr0: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 16'($urandom),
                  ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
      end
      rsp_ready = NR'($urandom);
      #1;
      n_cmp++; if (req_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, m_ready()); end
      n_cmp++; if (rsp_valid !== m_rv_vec()) begin n_bad++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, rsp_valid, m_rv_vec()); end
      n_cmp++; if (rsp_data !== m_rd_vec()) begin n_bad++; $display("FAIL rnd_rsp_data c%0d: got %h want %h", c, rsp_data, m_rd_vec()); end
      n_cmp++; if (rsp_dz !== m_rz_vec()) begin n_bad++; $display("FAIL rnd_rsp_dz c%0d: got %b want %b", c, rsp_dz, m_rz_vec()); end
      n_cmp++; if (idle !== m_idle()) begin n_bad++; $display("FAIL rnd_idle c%0d: got %b want %b", c, idle, m_idle()); end
      n_cmp++; if (div_num !== m_dnum || div_den !== m_dden) begin n_bad++; $display("FAIL rnd_div c%0d: got %h/%h want %h/%h", c, div_num, div_den, m_dnum, m_dden); end
      g = m_pick();
      tick();
      if (g >= 0) begin
        if ($urandom_range(0, 1) == 1)
          set_req(g, 16'($urandom), 16'($urandom_range(0, 40)));
        else
          req_valid[g] = 1'b0;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_backpressure();
    test_div_zero();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
